// File: rtl/matrix_result_serializer_pkg.sv
// Shared types and helpers for the accumulator-vector serializer.
package matrix_result_serializer_pkg;

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  function automatic int unsigned idx_width(input int unsigned d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/matrix_result_serializer_acc_requantize.sv
// Combinational requantizer: 2W-bit accumulator to W-bit fixed point, round half toward +inf.
// With SATURATE_EN defined the result is clamped and o_sat flags the clamp; otherwise it wraps.
module acc_requantize #(
  parameter int unsigned W    = 16,
  parameter int unsigned FRAC = 12
) (
  input  logic [2*W-1:0] i_acc,
  output logic [W-1:0]   o_q,
  output logic           o_sat
);

  localparam int unsigned AW = 2 * W + 1;
  localparam logic signed [AW-1:0] Half = AW'(64'd1 << (FRAC - 1));

  logic signed [AW-1:0] w_sum;
  logic signed [AW-1:0] w_t;

  // One guard bit keeps the rounding add from overflowing.
  assign w_sum = $signed({i_acc[2*W-1], i_acc}) + Half;
  assign w_t   = w_sum >>> FRAC;

`ifdef SATURATE_EN
  localparam logic signed [AW-1:0] MaxV = AW'((64'd1 << (W - 1)) - 64'd1);
  localparam logic signed [AW-1:0] MinV = ~MaxV;

  always_comb begin
    o_q   = w_t[W-1:0];
    o_sat = 1'b0;
    if (w_t > MaxV) begin
      o_q   = {1'b0, {(W - 1){1'b1}}};
      o_sat = 1'b1;
    end else if (w_t < MinV) begin
      o_q   = {1'b1, {(W - 1){1'b0}}};
      o_sat = 1'b1;
    end
  end
`else
  logic w_t_unused;

  assign w_t_unused = ^w_t[AW-1:W];
  assign o_q        = w_t[W-1:0];
  assign o_sat      = 1'b0;
`endif

endmodule

// File: rtl/matrix_result_serializer.sv
// Captures a packed vector of D accumulators and streams requantized elements one per cycle.
// Define SATURATE_EN to clamp instead of wrap and to expose the sticky sat_flag output.
module matrix_result_serializer
  import matrix_result_serializer_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter int unsigned D    = 8,
  parameter int unsigned FRAC = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*D*W-1:0]     packed_in,
  input  logic                 in_v,
  output logic                 in_ready,
  output logic [W-1:0]         out,
  output logic                 out_v,
  input  logic                 out_ready,
  output logic [$clog2(D)-1:0] out_idx,
  output logic                 out_last
`ifdef SATURATE_EN
  ,
  output logic                 sat_flag
`endif
);

  localparam int unsigned IW = idx_width(D);
  localparam logic [IW-1:0] LastIdx = IW'(D - 1);

  state_e           r_state;
  logic [2*D*W-1:0] r_buf;
  logic [W-1:0]     r_out;
  logic             r_out_v;
  logic [IW-1:0]    r_idx;
  logic             r_last;

  logic             w_fire;
  logic             w_capture;
  logic [IW-1:0]    w_next_idx;
  logic [2*W-1:0]   w_sel;
  logic [2*W-1:0]   w_rq_in;
  logic [W-1:0]     w_rq;

  assign w_fire     = r_out_v && out_ready;
  assign in_ready   = !rst && ((r_state == IDLE) || (w_fire && r_last));
  assign w_capture  = in_v && in_ready;
  assign w_next_idx = r_idx + IW'(1);

  always_comb begin
    w_sel = '0;
    for (int j = 0; j < int'(D); j++) begin
      if (w_next_idx == IW'(j)) w_sel = r_buf[(int'(D) - 1 - j)*2*W +: 2*W];
    end
  end

  // A fresh capture requantizes element 0 straight from the input bus.
  assign w_rq_in = w_capture ? packed_in[2*D*W-1 -: 2*W] : w_sel;

`ifdef SATURATE_EN
  logic w_sat;
  logic r_sat;

  assign sat_flag = r_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat <= 1'b0;
    end else if (w_sat && (w_capture || (w_fire && !r_last))) begin
      r_sat <= 1'b1;
    end
  end
`else
  logic w_sat_unused;
`endif

  acc_requantize #(
    .W   (W),
    .FRAC(FRAC)
  ) u_rq (
    .i_acc(w_rq_in),
    .o_q  (w_rq),
`ifdef SATURATE_EN
    .o_sat(w_sat)
`else
    .o_sat(w_sat_unused)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_out   <= '0;
      r_out_v <= 1'b0;
      r_idx   <= '0;
      r_last  <= 1'b0;
    end else if (w_capture) begin
      r_state <= STREAM;
      r_buf   <= packed_in;
      r_out   <= w_rq;
      r_out_v <= 1'b1;
      r_idx   <= '0;
      r_last  <= 1'b0;
    end else if (w_fire) begin
      if (!r_last) begin
        r_out  <= w_rq;
        r_idx  <= w_next_idx;
        r_last <= (w_next_idx == LastIdx);
      end else begin
        // Final handshake with nothing waiting: out and out_idx keep their last values.
        r_state <= IDLE;
        r_out_v <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign out      = r_out;
  assign out_v    = r_out_v;
  assign out_idx  = r_idx;
  assign out_last = r_last;

endmodule

// File: doc/matrix_result_serializer.md
# matrix_result_serializer

Consumes the wide packed accumulator vector produced by a row-by-matrix multiply stage: D signed 2W-bit dot-product results with a level-valid flag. It captures the vector, requantizes each accumulator back to a W-bit fixed-point value with rounding, and streams the elements out one per cycle under a valid/ready handshake. It sits between a matrix-multiply layer and the next per-element consumer, such as an activation or the next layer's input shifter.

## Interface
- W, 16, element width of the output; accumulators are 2W bits.
- D, 8, number of accumulators per vector (D ≥ 2).
- FRAC, 12, fractional bits to drop when requantizing (1 ≤ FRAC < 2W−W).
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- packed_in  input  2*D*W  signed accumulators. Element j occupies [(D−j)*2W−1 : (D−j−1)*2W], so element 0 is the MSB slice.
- in_v  input  1  packed_in valid. Level signal; upstream holds it until accepted.
- in_ready  output  1  block can capture this cycle (combinational).
- out  output  W  signed requantized element (registered).
- out_v  output  1  out valid (registered).
- out_ready  input  1  downstream accepts out this cycle.
- out_idx  output  $clog2(D)  index of the element on out (registered).
- out_last  output  1  high while out_idx == D−1 and out_v (registered).
- sat_flag  output  1  sticky saturation indicator; present only with SATURATE_EN.

## Operation
- **States:**
  - IDLE: no vector held.
  - STREAM: buffer holds a vector and elements are being emitted.
- **Ready:**
  - in_ready = !rst && (state==IDLE || (out_v && out_ready && out_last)).
- **Capture** (in_v && in_ready):
  - buffer <= packed_in.
  - out <= rq(element 0); out_idx <= 0; out_v <= 1.
  - State goes to STREAM.
- **Advance** (out_v && out_ready && !out_last):
  - out <= rq(buffer element out_idx+1); out_idx increments.
- **Last handshake** (out_v && out_ready && out_last):
  - If in_v is also high, capture the new vector in the same edge; no bubble.
  - Otherwise out_v <= 0 and state goes to IDLE. out and out_idx hold their values.
- **Stall:** out_v high with out_ready low holds out, out_idx and out_last stable.
- **In_v while not ready:** ignored; the buffer is unchanged.
- **rq(x):**
  - t = (x + 2^(FRAC−1)) >>> FRAC, evaluated in 2W+1 signed bits. This rounds half toward +∞.
  - Narrowing to W bits is set by the configuration below.
- **Reset** (async, any state, mid-stream included):
  - State returns to IDLE and the buffer clears to 0.
  - out=0, out_v=0, out_idx=0, out_last=0, sat_flag=0.
  - Any partially streamed vector is discarded.

## Timing
- Capture at edge N: out_v=1 with element 0 during cycle N+1.
- Element k is presented no earlier than cycle N+1+k.
- With out_ready held high, a full vector takes D cycles.
- Back-to-back vectors stream with zero idle cycles. Sustained throughput is 1 element/cycle.
- The in_ready path is combinational from out_ready and registered state. There is no combinational path from in_v to out.
- After rst deasserts, in_ready=1 in the first cycle.

## Configuration
- **SATURATE_EN defined:**
  - If t > 2^(W−1)−1, out = 2^(W−1)−1. If t < −2^(W−1), out = −2^(W−1).
  - Any clamp sets sat_flag, which stays set until rst.
- **SATURATE_EN undefined:**
  - out = t[W−1:0], which wraps.
  - The sat_flag port is absent and no clamp logic is built.

## Structure
- **Shared package:** state enum (IDLE, STREAM), and a localparam helper for the $clog2(D) index width.
- **Sub-module:** acc_requantize, combinational.
  - Parameters W and FRAC.
  - Ports: 2W-bit input, W-bit output, and a sat output (tied 0 without SATURATE_EN).
  - One instance is used, fed from a mux on the buffer at the next index.

## Test plan
All scenarios use D=4, W=16, FRAC=12.
- **Unity:** element 0 = 0x0100_0000 (1.0·1.0), others 0 -> out sequence 0x1000, 0, 0, 0; out_last only on idx 3; out_v low after the 4th handshake.
- **Rounding:** elements 0x0000_0800, 0x0000_07FF, 0xFFFF_F800, 0xFFFF_F7FF -> out 1, 0, 0, 0xFFFF.
- **Saturation:** element 0x7FFF_FFFF -> with SATURATE_EN, 0x7FFF and sat_flag=1. Without it, 0x0000. Element 0x8000_0000 -> 0x8000 (SATURATE_EN).
- **Backpressure:** toggle out_ready 1,0,0,1,… -> out and out_idx stable during the low cycles; all 4 elements emitted in order, none duplicated; in_v held high is ignored until the last handshake.
- **Back-to-back:** in_v high continuously with two distinct vectors, out_ready=1 -> 8 consecutive out_v cycles; the second vector is captured on the same edge as the first vector's idx-3 handshake.
- **Reset mid-stream:** assert rst asynchronously at idx 2 -> all outputs 0 immediately. After release, in_ready=1 and a new vector streams from idx 0.
